// File: rtl/draw_sequencer.sv
// Sequences a screen-fill client and a shape-draw client onto one VGA pixel port,
// clipping off-screen pixels and counting every pixel forwarded during a job.
module draw_sequencer #(
  parameter bit SKIP_FILL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        fill_start,
  input  logic        fill_finished,
  input  logic [7:0]  fill_x,
  input  logic [6:0]  fill_y,
  input  logic [2:0]  fill_colour,
  input  logic        fill_plot,
  output logic        draw_start,
  input  logic        draw_finished,
  input  logic [7:0]  draw_x,
  input  logic [6:0]  draw_y,
  input  logic [2:0]  draw_colour,
  input  logic        draw_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [14:0] plot_count
);

  typedef enum logic [1:0] {StIdle, StFill, StDraw, StDone} state_e;

  state_e      state_q;
  logic [14:0] plot_count_q;
  logic        sel_plot;

  // Client select; idle and done present an all-zero pixel port.
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    sel_plot   = 1'b0;
    case (state_q)
      StFill: begin
        vga_x      = fill_x;
        vga_y      = fill_y;
        vga_colour = fill_colour;
        sel_plot   = fill_plot;
      end
      StDraw: begin
        vga_x      = draw_x;
        vga_y      = draw_y;
        vga_colour = draw_colour;
        sel_plot   = draw_plot;
      end
      default: ;
    endcase
  end

  // Coordinates pass through untouched; only the strobe is clipped.
  assign vga_plot   = sel_plot && (vga_x < 8'd160) && (vga_y < 7'd120);
  assign fill_start = (state_q == StFill);
  assign draw_start = (state_q == StDraw);
  assign done       = (state_q == StDone);
  assign plot_count = plot_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      plot_count_q <= 15'd0;
    end else begin
      case (state_q)
        StIdle: if (start) state_q <= SKIP_FILL ? StDraw : StFill;
        StFill: begin
          if (!start)             state_q <= StIdle;
          else if (fill_finished) state_q <= StDraw;
        end
        StDraw: begin
          if (!start)             state_q <= StIdle;
          else if (draw_finished) state_q <= StDone;
        end
        StDone: if (!start) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (state_q == StIdle && start) begin
        plot_count_q <= 15'd0;
      end else if (vga_plot && plot_count_q != 15'h7fff) begin
        plot_count_q <= plot_count_q + 15'd1;
      end
    end
  end

endmodule
